// File: rtl/vecmac_accumulator.sv
// Signed int8 multiply-accumulate stage: registered 16-bit product, wide accumulator
// closed by in_last, and a valid/ready result port with element count and sticky overflow.
module vecmac_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]              state_r;
    logic signed [15:0]      p_r;
    logic                    p_vld_r;
    logic                    p_last_r;
    logic                    last_pend_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        count_r;
    logic                    ovf_r;

    logic                    accept_s;
    logic                    out_fire_s;
    logic signed [15:0]      a_ext_s;
    logic signed [15:0]      b_ext_s;
    logic signed [15:0]      prod_s;
    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    sum_ovf_s;
    logic                    count_sat_s;

    // Handshake decode, product, sign extension and overflow detection.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        if (!rst) begin
            in_ready  = (state_r == ST_ACCUM) && !last_pend_r;
            out_valid = (state_r == ST_DONE);
        end else begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
        accept_s    = in_valid && in_ready;
        out_fire_s  = out_valid && out_ready;
        // 16-bit operands keep -128 * -128 = +16384 exact.
        a_ext_s     = {{8{in_a[7]}}, in_a};
        b_ext_s     = {{8{in_b[7]}}, in_b};
        prod_s      = a_ext_s * b_ext_s;
        p_ext_s     = {{(ACC_W-16){p_r[15]}}, p_r};
        sum_s       = acc_r + p_ext_s;
        sum_ovf_s   = (acc_r[ACC_W-1] == p_ext_s[ACC_W-1]) &&
                      (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
        count_sat_s = (count_r == {CNT_W{1'b1}});
    end

    // Result port is a direct view of the accumulator state, forced to zero in reset.
    always_comb begin
        out_acc   = {ACC_W{1'b0}};
        out_count = {CNT_W{1'b0}};
        out_ovf   = 1'b0;
        if (!rst) begin
            out_acc   = acc_r;
            out_count = count_r;
            out_ovf   = ovf_r;
        end else begin
            out_acc   = {ACC_W{1'b0}};
            out_count = {CNT_W{1'b0}};
            out_ovf   = 1'b0;
        end
    end

    // Product stage, accumulation stage and ACCUM/DONE sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACCUM;
            p_r         <= 16'sd0;
            p_vld_r     <= 1'b0;
            p_last_r    <= 1'b0;
            last_pend_r <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                p_r      <= prod_s;
                p_vld_r  <= 1'b1;
                p_last_r <= in_last;
                if (in_last) begin
                    last_pend_r <= 1'b1;
                end
            end else begin
                p_vld_r  <= 1'b0;
                p_last_r <= 1'b0;
            end

            case (state_r)
                ST_ACCUM: begin
                    if (p_vld_r) begin
                        acc_r <= sum_s;
                        if (!count_sat_s) begin
                            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        if (sum_ovf_s) begin
                            ovf_r <= 1'b1;
                        end
                        if (p_last_r) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // No input can be accepted here, so clearing cannot race an accumulate.
                    if (out_fire_s) begin
                        acc_r       <= {ACC_W{1'b0}};
                        count_r     <= {CNT_W{1'b0}};
                        ovf_r       <= 1'b0;
                        last_pend_r <= 1'b0;
                        state_r     <= ST_ACCUM;
                    end
                end
                default: begin
                    state_r <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vecmac_accumulator.sv
// Directed and random bench for vecmac_accumulator; a default-width instance and a
// narrow instance (ACC_W=17, CNT_W=4) for wrap and count saturation.
module tb_vecmac_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       drv_valid;
    logic       drv_last;
    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic       out_rdy;

    logic        in_ready1, out_valid1, out_ovf1;
    logic [31:0] out_acc1;
    logic [15:0] out_count1;
    logic        in_ready2, out_valid2, out_ovf2;
    logic [16:0] out_acc2;
    logic [3:0]  out_count2;

    vecmac_accumulator u_dut (
        .clk(clk), .rst(rst),
        .in_valid(drv_valid && !sel), .in_ready(in_ready1),
        .in_a(drv_a), .in_b(drv_b), .in_last(drv_last),
        .out_valid(out_valid1), .out_ready(out_rdy && !sel),
        .out_acc(out_acc1), .out_count(out_count1), .out_ovf(out_ovf1)
    );

    vecmac_accumulator #(.ACC_W(17), .CNT_W(4)) u_dut_narrow (
        .clk(clk), .rst(rst),
        .in_valid(drv_valid && sel), .in_ready(in_ready2),
        .in_a(drv_a), .in_b(drv_b), .in_last(drv_last),
        .out_valid(out_valid2), .out_ready(out_rdy && sel),
        .out_acc(out_acc2), .out_count(out_count2), .out_ovf(out_ovf2)
    );

    logic               mo_ready, mo_valid, mo_ovf;
    logic signed [63:0] mo_acc;
    logic signed [63:0] mo_cnt;

    always_comb begin
        if (sel) begin
            mo_ready = in_ready2;
            mo_valid = out_valid2;
            mo_ovf   = out_ovf2;
            mo_acc   = {{47{out_acc2[16]}}, out_acc2};
            mo_cnt   = {60'd0, out_count2};
        end else begin
            mo_ready = in_ready1;
            mo_valid = out_valid1;
            mo_ovf   = out_ovf1;
            mo_acc   = {{32{out_acc1[31]}}, out_acc1};
            mo_cnt   = {48'd0, out_count1};
        end
    end

    int checks = 0;
    int passed = 0;

    // reference model of the vector in flight, and the scoreboard of finished results
    longint m_acc = 0;
    longint m_cnt = 0;
    bit     m_ovf = 1'b0;
    longint q_acc[$];
    longint q_cnt[$];
    bit     q_ovf[$];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_add(input int a, input int b, input bit last);
        longint w, cw, t, span;
        w    = sel ? 64'sd17 : 64'sd32;
        cw   = sel ? 64'sd4 : 64'sd16;
        span = longint'(1) << w;
        t    = m_acc + longint'(a * b);
        if (t > (span / 2) - 1) begin
            t = t - span;
            m_ovf = 1'b1;
        end else if (t < -(span / 2)) begin
            t = t + span;
            m_ovf = 1'b1;
        end
        m_acc = t;
        if (m_cnt < (longint'(1) << cw) - 1) m_cnt++;
        if (last) begin
            q_acc.push_back(m_acc);
            q_cnt.push_back(m_cnt);
            q_ovf.push_back(m_ovf);
            model_clear();
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input int a, input int b, input bit last, output int waited);
        drv_valid = 1'b1;
        drv_a     = a[7:0];
        drv_b     = b[7:0];
        drv_last  = last;
        waited    = 0;
        #1;
        while (!mo_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!mo_ready) begin
            check("accept_timeout", mo_ready, 1);
            drv_valid = 1'b0;
        end else begin
            @(negedge clk);
            model_add(a, b, last);
            if (last) drv_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic recv(input int hold);
        int     w;
        longint e_acc, e_cnt;
        bit     e_ovf;
        w = 0;
        #1;
        while (!mo_valid && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("out_valid_seen", mo_valid, 1);
        if (mo_valid) begin
            if (q_acc.size() == 0) begin
                check("scoreboard_nonempty", q_acc.size(), 1);
            end else begin
                e_acc = q_acc.pop_front();
                e_cnt = q_cnt.pop_front();
                e_ovf = q_ovf.pop_front();
                for (int i = 0; i < hold; i++) begin
                    check("held_acc", mo_acc, e_acc);
                    check("held_in_ready", mo_ready, 0);
                    @(negedge clk);
                    #1;
                end
                check("out_acc", mo_acc, e_acc);
                check("out_count", mo_cnt, e_cnt);
                check("out_ovf", mo_ovf, e_ovf);
                check("out_valid_held", mo_valid, 1);
            end
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
            #1;
            check("out_valid_after_hs", mo_valid, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, mo_ready, 0);
        check({tag, "_out_valid"}, mo_valid, 0);
        check({tag, "_out_acc"}, mo_acc, 0);
        check({tag, "_out_count"}, mo_cnt, 0);
        check({tag, "_out_ovf"}, mo_ovf, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int wt, remaining, len, a, b;
        rst = 1'b1; sel = 1'b0; drv_valid = 1'b0; drv_last = 1'b0;
        drv_a = 8'd0; drv_b = 8'd0; out_rdy = 1'b0;

        // reset values on both instances
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst_w32");
        sel = 1'b1;
        #1;
        check_reset_outputs("rst_w17");
        sel = 1'b0;
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", mo_ready, 1);
        @(negedge clk);

        // basic dot product, back to back, with latency and in_ready drop
        for (int i = 0; i < 4; i++) begin
            send(i + 1, i + 5, i == 3, wt);
            check("b2b_wait", wt, 0);
        end
        #1;
        check("lat_valid_early", mo_valid, 0);
        check("in_ready_drop", mo_ready, 0);
        @(negedge clk);
        #1;
        check("lat_valid_on_time", mo_valid, 1);
        recv(0);

        // single elements and sign handling
        send(-3, 7, 1'b1, wt);
        recv(0);
        send(-128, -128, 1'b1, wt);
        recv(0);

        // backpressure: element held while the result waits
        send(3, 3, 1'b1, wt);
        drv_valid = 1'b1; drv_a = 8'd2; drv_b = 8'd2; drv_last = 1'b1;
        recv(5);
        check("restart_in_ready", mo_ready, 1);
        @(negedge clk);
        drv_valid = 1'b0;
        model_add(2, 2, 1'b1);
        recv(0);

        // reset mid-vector
        send(10, 10, 1'b0, wt);
        send(10, 10, 1'b0, wt);
        drv_valid = 1'b0;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        #1;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        #1;
        check("in_ready_after_rst_mid", mo_ready, 1);
        send(2, 3, 1'b1, wt);
        recv(0);

        // narrow instance: accumulator wrap, then fresh vector, then count saturation
        idle(1);
        sel = 1'b1;
        for (int i = 0; i < 4; i++) send(-128, -128, i == 3, wt);
        recv(1);
        send(1, 1, 1'b1, wt);
        recv(0);
        for (int i = 0; i < 20; i++) send(1, 1, i == 19, wt);
        recv(0);
        idle(1);
        sel = 1'b0;

        // random stream with input and output gaps
        remaining = 1000;
        while (remaining > 0) begin
            len = int'($urandom_range(64, 1));
            if (len > remaining) len = remaining;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
                a = int'($urandom_range(255, 0)) - 128;
                b = int'($urandom_range(255, 0)) - 128;
                send(a, b, i == len - 1, wt);
            end
            recv(int'($urandom_range(3, 0)));
            remaining = remaining - len;
        end
        check("scoreboard_drained", q_acc.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
